// File: rtl/ss_mul_16b.sv
// ss_mul_16b: sequential unsigned shift-add multiplier.
// One shift-add step is taken per clock in RUN, so a WIDTH x WIDTH product
// needs WIDTH steps. Operands are captured when start is accepted, and the
// product registers change only when the final step completes.
module ss_mul_16b #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] prod_hi,
   output logic [WIDTH-1:0] prod_lo
);

   // The step counter needs to hold WIDTH-1. One extra bit of headroom keeps
   // it clear of wrap-around.
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   // One shift-add step. Add the multiplicand into the upper half when the
   // multiplier LSB is set. The add has a carry out. Then shift
   // {carry, acc, multiplier} right by one. The result is {new acc, new mlr}.
   function automatic logic [2*WIDTH-1:0] shift_add_step(
      input logic [WIDTH-1:0] acc,
      input logic [WIDTH-1:0] mlr,
      input logic [WIDTH-1:0] mcand
   );
      logic [WIDTH:0]   sum;
      logic [WIDTH-1:0] addend;
      addend = mlr[0] ? mcand : {WIDTH{1'b0}};
      sum    = {1'b0, acc} + {1'b0, addend};
      return {sum, mlr[WIDTH-1:1]};
   endfunction

   state_t           state_q,   state_d;
   logic [WIDTH-1:0] mcand_q,   mcand_d;
   logic [WIDTH-1:0] acc_q,     acc_d;
   logic [WIDTH-1:0] mlr_q,     mlr_d;
   logic [CW-1:0]    cnt_q,     cnt_d;
   logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
   logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
   logic             busy_q,    busy_d;
   logic             done_q,    done_d;
   logic [2*WIDTH-1:0] step_s;

   // Next-state and datapath logic. This process also handles operand
   // capture, the step counter and the final product load.
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      mlr_d     = mlr_q;
      cnt_d     = cnt_q;
      prod_hi_d = prod_hi_q;
      prod_lo_d = prod_lo_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      step_s    = shift_add_step(acc_q, mlr_q, mcand_q);

      case (state_q)
         S_IDLE, S_DONE: begin
            // A start in DONE is accepted just like a start in IDLE, so
            // back-to-back operations need no idle cycle in between.
            if (start) begin
               mcand_d = a;
               mlr_d   = b;
               acc_d   = {WIDTH{1'b0}};
               cnt_d   = CNT_ZERO;
               state_d = S_RUN;
               busy_d  = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            // start is ignored here. The operation in flight runs to the end.
            acc_d = step_s[2*WIDTH-1:WIDTH];
            mlr_d = step_s[WIDTH-1:0];
            if (cnt_q == LAST_STEP) begin
               prod_hi_d = step_s[2*WIDTH-1:WIDTH];
               prod_lo_d = step_s[WIDTH-1:0];
               cnt_d     = CNT_ZERO;
               state_d   = S_DONE;
               done_d    = 1'b1;
            end else begin
               cnt_d     = cnt_q + CNT_ONE;
               state_d   = S_RUN;
               busy_d    = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Register all state and the outputs. Reset clears everything
   // asynchronously, which also aborts any operation in flight.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         mcand_q   <= {WIDTH{1'b0}};
         acc_q     <= {WIDTH{1'b0}};
         mlr_q     <= {WIDTH{1'b0}};
         cnt_q     <= CNT_ZERO;
         prod_hi_q <= {WIDTH{1'b0}};
         prod_lo_q <= {WIDTH{1'b0}};
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         mlr_q     <= mlr_d;
         cnt_q     <= cnt_d;
         prod_hi_q <= prod_hi_d;
         prod_lo_q <= prod_lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign prod_hi = prod_hi_q;
   assign prod_lo = prod_lo_q;

endmodule
